// File: rtl/strawman_tx_arbiter.sv
// strawman_tx_arbiter
// Round-robin front end that shares one strawman_tx_fsm among NUM_REQ packet
// sources. The design accepts one packet at a time and holds it on the FSM
// protocol bus. It raises o_valid for one packet start and uses the FSM flit
// strobe to detect when the packet is finished. It drops malformed packets and
// aborts a packet if the FSM never starts it.
module strawman_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int LOG2_NUM_REQ   = 2,
  parameter int BUS_WIDTH      = 1076,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ*BUS_WIDTH-1:0] i_req_bus,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic [BUS_WIDTH-1:0]         o_protocol_bus,
  output logic                         o_valid,
  input  logic                         i_flit_valid,
  output logic [LOG2_NUM_REQ-1:0]      o_grant_id,
  output logic                         o_busy,
  output logic                         o_timeout,
  output logic [7:0]                   o_drop_count
);

  localparam logic [1:0] ST_ARB   = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  // ISSUE leaves on the cycle in which the counter would reach TIMEOUT_CYCLES.
  localparam logic [7:0]              TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [LOG2_NUM_REQ-1:0] LAST_RESET   = LOG2_NUM_REQ'(NUM_REQ - 1);

  logic [1:0]              state;
  logic [LOG2_NUM_REQ-1:0] last;
  logic [7:0]              timeout_cnt;

  logic                    any_valid;
  logic [LOG2_NUM_REQ-1:0] winner;
  logic [BUS_WIDTH-1:0]    win_bus;
  logic                    malformed;

  // Round-robin search that starts at last+1. The loop runs from the farthest
  // offset to the nearest one, so the nearest valid requester is written last and wins.
  always_comb begin
    // NOTE: each signal gets a default value before the loop. Every path then
    // assigns it, so synthesis does not infer a latch.
    any_valid = 1'b0;
    winner    = last;
    for (int i = NUM_REQ; i >= 1; i--) begin
      if (i_req_valid[(int'(last) + i) % NUM_REQ]) begin
        any_valid = 1'b1;
        winner    = LOG2_NUM_REQ'((int'(last) + i) % NUM_REQ);
      end
    end
  end

  // Decode the winning packet. It is malformed if the valid bit is clear or the cmd value is unknown.
  always_comb begin
    win_bus   = i_req_bus[int'(winner)*BUS_WIDTH +: BUS_WIDTH];
    malformed = !win_bus[1] || (win_bus[4:2] > 3'b010);
  end

  // The accept pulse is combinational and only occurs in ARB. It is gated off while reset is asserted.
  always_comb begin
    o_req_ready = '0;
    if (!rst && state == ST_ARB && any_valid) begin
      o_req_ready = NUM_REQ'(1) << winner;
    end
  end

  assign o_valid = (state == ST_ISSUE);
  assign o_busy  = (state != ST_ARB);

  // Arbitration/issue/drain sequencing, held packet, timeout and drop count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= ST_ARB;
      last           <= LAST_RESET;
      o_protocol_bus <= '0;
      o_grant_id     <= '0;
      timeout_cnt    <= '0;
      o_timeout      <= 1'b0;
      o_drop_count   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments. All registers then
      // update together at the edge, whatever order the statements are in.
      o_timeout <= 1'b0;
      case (state)
        ST_ARB: begin
          if (any_valid) begin
            last <= winner;
            if (malformed) begin
              if (o_drop_count != 8'hff) o_drop_count <= o_drop_count + 8'd1;
            end else begin
              o_protocol_bus <= win_bus;
              o_grant_id     <= winner;
              timeout_cnt    <= '0;
              state          <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (i_flit_valid) begin
            state <= ST_DRAIN;
          end else begin
            timeout_cnt <= timeout_cnt + 8'd1;
            if (timeout_cnt == TIMEOUT_LAST) begin
              state     <= ST_ARB;
              o_timeout <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (!i_flit_valid) state <= ST_ARB;
        end
        default: state <= ST_ARB;
      endcase
    end
  end

endmodule
